// File: rtl/ram_downscaler.sv
`default_nettype none
// ============================================================================
//  Module   : ram_downscaler
//  Purpose  : Reads a (2S)x(2S) DW-bit image from the frame RAM and writes an
//             SxS image to the output memory, where S = 2**SIDE_LOG2. Each
//             output pixel is the round-half-up average of one 2x2 RAM block.
//             This is the inverse of the 2x pixel-replicating upscale path.
//             At the default SIDE_LOG2=7 this converts 256x256 -> 128x128.
//  Ports    :
//    clk     in   system clock, rising edge
//    rst     in   asynchronous active-high reset
//    start   in   one-cycle pulse, begins a frame when not busy
//    RAM_A   out  RAM read address {row, col}, zero-extended to 16 bits
//    RAM_OE  out  RAM read enable
//    RAM_Q   in   RAM read data, valid the cycle after RAM_A/RAM_OE
//    OUT_A   out  output memory address {row, col}, zero-extended to 14 bits
//    OUT_WE  out  output memory write enable, one cycle per pixel
//    OUT_D   out  output pixel data
//    busy    out  high while a frame is being converted
//    done    out  high once the frame is complete, until start or rst
//  Revision : 1.0 - initial release
// ============================================================================
module ram_downscaler #(
  parameter int DW        = 8,
  parameter int SIDE_LOG2 = 7   // log2 of the output image side, 1..7
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  output logic [15:0]   RAM_A,
  output logic          RAM_OE,
  input  logic [DW-1:0] RAM_Q,
  output logic [13:0]   OUT_A,
  output logic          OUT_WE,
  output logic [DW-1:0] OUT_D,
  output logic          busy,
  output logic          done
);

  localparam int c_IDX_W = 2 * SIDE_LOG2;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RD0   = 3'd1,
    S_RD1   = 3'd2,
    S_RD2   = 3'd3,
    S_RD3   = 3'd4,
    S_ACC   = 3'd5,
    S_WR    = 3'd6,
    S_FINAL = 3'd7
  } state_t;

  state_t               r_state;
  logic [c_IDX_W-1:0]   r_idx;   // output pixel index {r, c}
  logic [DW+1:0]        r_sum;   // 2x2 block accumulator

  logic [DW+1:0]        w_q_ext;
  logic [DW+1:0]        w_sum_q;
  logic [DW+1:0]        w_round;
  logic [c_IDX_W-1:0]   w_idx_inc;
  logic                 w_last;

  // Source address of one pixel of the 2x2 block behind output pixel idx:
  // {r, dy, c, dx}. The column field carries into the row naturally.
  function automatic logic [15:0] blk_addr(input logic [c_IDX_W-1:0] idx,
                                           input logic dy, input logic dx);
    logic [c_IDX_W+1:0] a;
    a = {idx[c_IDX_W-1 -: SIDE_LOG2], dy, idx[SIDE_LOG2-1:0], dx};
    return 16'(a);
  endfunction

  assign w_q_ext   = {2'b00, RAM_Q};
  assign w_sum_q   = r_sum + w_q_ext;
  // Four DW-bit values plus 2 always fit in DW+2 bits, so no wrap here.
  assign w_round   = w_sum_q + (DW+2)'(2);
  assign w_idx_inc = r_idx + c_IDX_W'(1);
  assign w_last    = &r_idx;

  // Outputs are registered alongside the state: each transition loads the
  // output values that belong to the destination state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_idx   <= '0;
      r_sum   <= '0;
      RAM_A   <= '0;
      RAM_OE  <= 1'b0;
      OUT_A   <= '0;
      OUT_WE  <= 1'b0;
      OUT_D   <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      OUT_WE <= 1'b0;
      case (r_state)
        S_IDLE, S_FINAL: begin
          if (start) begin
            r_state <= S_RD0;
            r_idx   <= '0;
            RAM_A   <= '0;
            RAM_OE  <= 1'b1;
            busy    <= 1'b1;
            done    <= 1'b0;
          end
        end
        S_RD0: begin
          r_state <= S_RD1;
          RAM_A   <= blk_addr(r_idx, 1'b0, 1'b1);
        end
        S_RD1: begin
          // Data for the RD0 address arrives now and seeds the sum.
          r_sum   <= w_q_ext;
          r_state <= S_RD2;
          RAM_A   <= blk_addr(r_idx, 1'b1, 1'b0);
        end
        S_RD2: begin
          r_sum   <= w_sum_q;
          r_state <= S_RD3;
          RAM_A   <= blk_addr(r_idx, 1'b1, 1'b1);
        end
        S_RD3: begin
          r_sum   <= w_sum_q;
          r_state <= S_ACC;
          RAM_A   <= '0;
          RAM_OE  <= 1'b0;
        end
        S_ACC: begin
          // Last pixel of the block lands here; the rounded average is
          // formed from the completed sum so OUT_D is valid in WR.
          r_sum   <= w_sum_q;
          r_state <= S_WR;
          OUT_WE  <= 1'b1;
          OUT_A   <= 14'(r_idx);
          OUT_D   <= w_round[DW+1:2];
        end
        S_WR: begin
          OUT_A <= '0;
          OUT_D <= '0;
          if (w_last) begin
            r_state <= S_FINAL;
            busy    <= 1'b0;
            done    <= 1'b1;
          end else begin
            r_state <= S_RD0;
            r_idx   <= w_idx_inc;
            RAM_A   <= blk_addr(w_idx_inc, 1'b0, 1'b0);
            RAM_OE  <= 1'b1;
          end
        end
        default: begin
          r_state <= S_IDLE;
          RAM_A   <= '0;
          RAM_OE  <= 1'b0;
          busy    <= 1'b0;
          done    <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: doc/ram_downscaler.md
# ram_downscaler

Reads a 256x256 8-bit image from the frame RAM and writes a 128x128 image to the output memory. Each output pixel is the rounded average of one 2x2 RAM block. The block is the inverse of the system's 2x pixel-replicating upscale path. It sits on the RAM read port and the output-memory write port, and is started by the top-level sequencer once the RAM frame is complete.

## Interface
- DW, 8, pixel data width
- clk  in  1  system clock, rising-edge
- rst  in  1  reset, asynchronous, active-high
- start  in  1  one-cycle pulse; begins a frame conversion when not busy
- RAM_A  out  16  RAM read address, {row[7:0], col[7:0]}
- RAM_OE  out  1  RAM read enable
- RAM_Q  in  DW  RAM read data, valid the cycle after RAM_A/RAM_OE are presented
- OUT_A  out  14  output memory address, {row[6:0], col[6:0]}
- OUT_WE  out  1  output memory write enable, one cycle per pixel
- OUT_D  out  DW  output pixel data
- busy  out  1  high from the cycle after start is accepted until done
- done  out  1  high in FINAL, held until a new start or rst

## Operation
- Registers:
  - state (IDLE, RD0, RD1, RD2, RD3, ACC, WR, FINAL)
  - idx[13:0] = {r[6:0], c[6:0]}, the output pixel index
  - sum[DW+1:0], the accumulator
- RAM address per state, with dy/dx selecting the pixel within the 2x2 block: RAM_A = {r, dy, c, dx}
  - RD0: dy=0, dx=0
  - RD1: dy=0, dx=1
  - RD2: dy=1, dx=0
  - RD3: dy=1, dx=1
  - RAM_OE=1 in RD0..RD3 only.
- Accumulation:
  - RD1: sum <= RAM_Q
  - RD2, RD3, ACC: sum <= sum + RAM_Q
  - ACC: RAM_OE=0, RAM_A=0
- WR:
  - OUT_WE=1, OUT_A=idx, OUT_D=(sum+2)>>2, truncated to DW bits.
  - Rounding is round-half-up. The width of sum guarantees no overflow: 4*255+2 = 1022 < 1024.
- Transitions:
  - IDLE -> RD0 on start; idx <= 0.
  - RD0 -> RD1 -> RD2 -> RD3 -> ACC -> WR, unconditionally.
  - WR -> FINAL if idx==14'h3FFF, else -> RD0 with idx <= idx+1. Column c wraps into row r naturally.
  - FINAL -> RD0 on start, with idx <= 0. Otherwise FINAL holds.
- start is ignored in RD0..WR.
- busy=1 in RD0..WR. done=1 in FINAL only.
- All outputs are Moore-decoded from state and registers. No combinational path from RAM_Q to any output except OUT_D via sum.

## Timing
- Reset values:
  - state=IDLE, idx=0, sum=0
  - RAM_A=0, RAM_OE=0, OUT_A=0, OUT_WE=0, OUT_D=0, busy=0, done=0
- rst mid-frame: immediate return to IDLE and all outputs 0. No further writes occur. Partial output contents are undefined.
- Start latency: start sampled high in IDLE at edge k puts the block in RD0 in cycle k+1, and the first RAM_A appears that cycle.
- 6 cycles per output pixel. The first OUT_WE occurs 5 cycles after the first RD0.
- Full frame: 16384*6 = 98304 cycles from the first RD0 to the cycle before FINAL. done rises in cycle 98304 after the first RD0.
- Exactly 16384 OUT_WE pulses per frame, with OUT_A strictly increasing 0..16383.
- Exactly 65536 RAM reads per frame. Each RAM address is read once.

## Test plan
- Address order: start -> first block reads RAM_A 0, 1, 256, 257 and writes OUT_A=0. The second block reads 2, 3, 258, 259 and writes OUT_A=1. The block at idx=128 reads 512, 513, 768, 769.
- Rounding: block values 1,1,1,0 -> OUT_D=1; 1,0,0,0 -> 0; 2,2,2,0 -> 2 (6+2=8>>2); 255 x4 -> 255 with no wrap.
- Full frame with RAM[a]=a[7:0]^a[15:8]: compare all 16384 outputs against the model; count 98304 cycles to done; done held for 100 idle cycles.
- start pulsed during busy (at idx=10) -> ignored; sequence and cycle count unchanged.
- rst asserted at idx=500 mid-RD2 -> all outputs 0 the same cycle. A following start restarts at idx=0 and completes normally.
- start in FINAL -> done drops next cycle, busy rises, and a second identical frame is produced.
